// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types_pkg
// Purpose  : Shared RV32 types and writeback-select encodings for the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } load_store_t;

  localparam logic [2:0] WSEL_LOAD  = 3'd0;
  localparam logic [2:0] WSEL_ALU   = 3'd3;
  localparam logic [2:0] WSEL_CSR   = 3'd4;
  localparam logic [1:0] FWSEL_FPU  = 2'd0;
  localparam logic [1:0] FWSEL_LOAD = 2'd1;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe5_dmem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe5_dmem_lane_unit
// Purpose  : Load extension, store byte-lane steering and misalignment check.
// Revision : 1.0 - initial release
// ============================================================================
module pipe5_dmem_lane_unit
  import rv32i_types_pkg::*;
(
  input  load_store_t ls_type,
  input  logic [1:0]  offset,
  input  word_t       store_data,
  input  word_t       load_rdata,
  output logic [3:0]  byte_en,
  output word_t       store_wdata,
  output word_t       load_ext,
  output logic        misaligned
);

  logic       w_is_byte;
  logic       w_is_half;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  // Access size comes from the type so byte-sized loads and stores share lanes.
  assign w_is_byte = ls_type inside {LB, LBU, SB};
  assign w_is_half = ls_type inside {LH, LHU, SH};

  always_comb begin
    w_byte = load_rdata[7:0];
    case (offset)
      2'd1:    w_byte = load_rdata[15:8];
      2'd2:    w_byte = load_rdata[23:16];
      2'd3:    w_byte = load_rdata[31:24];
      default: w_byte = load_rdata[7:0];
    endcase
  end

  assign w_half = offset[1] ? load_rdata[31:16] : load_rdata[15:0];

  always_comb begin
    load_ext = load_rdata;
    case (ls_type)
      LB:      load_ext = {{24{w_byte[7]}}, w_byte};
      LBU:     load_ext = {24'd0, w_byte};
      LH:      load_ext = {{16{w_half[15]}}, w_half};
      LHU:     load_ext = {16'd0, w_half};
      default: load_ext = load_rdata;
    endcase
  end

  always_comb begin
    byte_en     = 4'b1111;
    store_wdata = store_data;
    if (w_is_byte) begin
      byte_en     = 4'b0001 << offset;
      store_wdata = {4{store_data[7:0]}};
    end else if (w_is_half) begin
      byte_en     = offset[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{store_data[15:0]}};
    end
  end

  assign misaligned = (w_is_half & offset[0]) | (~w_is_byte & ~w_is_half & (|offset));

endmodule
`default_nettype wire

// File: rtl/pipe5_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe5_memory_stage
// Purpose  : Memory stage: dmem request/busy handshake and mem/wb register.
//            FP writeback fields are registered only with RV32F_SUPPORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe5_memory_stage
  import rv32i_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_dren,
  input  logic              ex_dwen,
  input  load_store_t       ex_ls_type,
  input  logic [2:0]        ex_w_sel,
  input  logic              ex_wen,
  input  logic [4:0]        ex_reg_rd,
  input  logic [DATA_W-1:0] ex_csr_rdata,
  input  logic [DATA_W-1:0] ex_reg_file_wdata,
  input  logic              ex_f_wen,
  input  logic [4:0]        ex_f_reg_rd,
  input  logic [1:0]        ex_f_wsel,
  input  logic [DATA_W-1:0] ex_fpu_out,
  input  logic [DATA_W-1:0] ex_f_wdata,
  input  logic              flush,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_busy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [3:0]        dmem_byte_en,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              mem_stall,
  output logic              misaligned_load,
  output logic              misaligned_store,
  output logic [DATA_W-1:0] mem_wb_alu_port_out,
  output logic [DATA_W-1:0] mem_wb_dload_ext,
  output logic [DATA_W-1:0] mem_wb_csr_rdata,
  output logic [DATA_W-1:0] mem_wb_reg_file_wdata,
  output logic [2:0]        mem_wb_w_sel,
  output logic              mem_wb_wen,
  output logic [4:0]        mem_wb_reg_rd,
  output logic [DATA_W-1:0] mem_wb_fpu_out,
  output logic [DATA_W-1:0] mem_wb_f_wdata,
  output logic [1:0]        mem_wb_f_wsel,
  output logic              mem_wb_f_wen,
  output logic [4:0]        mem_wb_f_reg_rd
);

  mem_state_t        r_state, w_next_state;
  logic              r_killed;
  logic              r_bus_ren, r_bus_wen;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  word_t             r_bus_wdata;
  logic [3:0]        w_lane_be;
  word_t             w_lane_wdata, w_load_ext;
  logic              w_lane_mis, w_mem_op, w_misaligned, w_new_req;
  logic              w_stall, w_commit, w_mis_load, w_mis_store;

  pipe5_dmem_lane_unit u_lane (
    .ls_type     (ex_ls_type),
    .offset      (ex_alu_out[1:0]),
    .store_data  (ex_store_data),
    .load_rdata  (dmem_rdata),
    .byte_en     (w_lane_be),
    .store_wdata (w_lane_wdata),
    .load_ext    (w_load_ext),
    .misaligned  (w_lane_mis)
  );

  assign w_mem_op     = ex_dren | ex_dwen;
  assign w_misaligned = w_mem_op & w_lane_mis;
  assign w_new_req    = ex_valid & w_mem_op & ~w_misaligned & ~flush;
  // A flushed instruction never raises an exception flag.
  assign w_mis_load   = (r_state == MEM_IDLE) & ex_valid & ~flush & ex_dren & ~ex_dwen & w_lane_mis;
  assign w_mis_store  = (r_state == MEM_IDLE) & ex_valid & ~flush & ex_dwen & w_lane_mis;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= MEM_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        w_stall  = w_new_req & dmem_busy;
        w_commit = ex_valid & ~flush & ~w_misaligned;
        if (w_stall) w_next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        w_stall  = dmem_busy;
        w_commit = ex_valid & ~flush & ~r_killed;
        if (!dmem_busy) w_next_state = MEM_IDLE;
      end
      default: w_next_state = MEM_IDLE;
    endcase
  end

  // Bus request is snapshotted every idle cycle and replayed unchanged in WAIT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_killed    <= 1'b0;
      r_bus_ren   <= 1'b0;
      r_bus_wen   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else if (r_state == MEM_IDLE) begin
      r_killed    <= 1'b0;
      r_bus_ren   <= w_new_req & ~ex_dwen;
      r_bus_wen   <= w_new_req & ex_dwen;
      r_bus_addr  <= {ex_alu_out[ADDR_W-1:2], 2'b00};
      r_bus_be    <= w_lane_be;
      r_bus_wdata <= w_lane_wdata;
    end else if (flush) begin
      r_killed    <= 1'b1;
    end
  end

  assign dmem_ren     = nRST & ((r_state == MEM_WAIT) ? r_bus_ren : (w_new_req & ~ex_dwen));
  assign dmem_wen     = nRST & ((r_state == MEM_WAIT) ? r_bus_wen : (w_new_req & ex_dwen));
  assign dmem_addr    = (r_state == MEM_WAIT) ? r_bus_addr : {ex_alu_out[ADDR_W-1:2], 2'b00};
  assign dmem_byte_en = (r_state == MEM_WAIT) ? r_bus_be : w_lane_be;
  assign dmem_wdata   = (r_state == MEM_WAIT) ? r_bus_wdata : w_lane_wdata;
  assign mem_stall    = nRST & w_stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_wb_alu_port_out   <= '0;
      mem_wb_dload_ext      <= '0;
      mem_wb_csr_rdata      <= '0;
      mem_wb_reg_file_wdata <= '0;
      mem_wb_w_sel          <= '0;
      mem_wb_wen            <= 1'b0;
      mem_wb_reg_rd         <= '0;
      misaligned_load       <= 1'b0;
      misaligned_store      <= 1'b0;
    end else begin
      misaligned_load  <= w_mis_load;
      misaligned_store <= w_mis_store;
      if (w_stall) begin
        mem_wb_wen <= 1'b0;
      end else begin
        mem_wb_alu_port_out   <= ex_alu_out;
        mem_wb_dload_ext      <= w_load_ext;
        mem_wb_csr_rdata      <= ex_csr_rdata;
        mem_wb_reg_file_wdata <= ex_reg_file_wdata;
        mem_wb_w_sel          <= ex_w_sel;
        mem_wb_wen            <= ex_wen & w_commit;
        mem_wb_reg_rd         <= ex_reg_rd;
      end
    end
  end

`ifdef RV32F_SUPPORT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_wb_fpu_out  <= '0;
      mem_wb_f_wdata  <= '0;
      mem_wb_f_wsel   <= '0;
      mem_wb_f_wen    <= 1'b0;
      mem_wb_f_reg_rd <= '0;
    end else if (w_stall) begin
      mem_wb_f_wen    <= 1'b0;
    end else begin
      mem_wb_fpu_out  <= ex_fpu_out;
      mem_wb_f_wdata  <= ex_f_wdata;
      mem_wb_f_wsel   <= ex_f_wsel;
      mem_wb_f_wen    <= ex_f_wen & w_commit;
      mem_wb_f_reg_rd <= ex_f_reg_rd;
    end
  end
`else
  logic w_fp_unused;
  assign w_fp_unused     = ^{ex_f_wen, ex_f_reg_rd, ex_f_wsel, ex_fpu_out, ex_f_wdata};
  assign mem_wb_fpu_out  = '0;
  assign mem_wb_f_wdata  = '0;
  assign mem_wb_f_wsel   = '0;
  assign mem_wb_f_wen    = 1'b0;
  assign mem_wb_f_reg_rd = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe5_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe5_memory_stage
// Purpose  : Self-checking bench for pipe5_memory_stage (vector table + model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe5_memory_stage;
  import rv32i_types_pkg::*;

`ifdef RV32F_SUPPORT_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, ex_dren, ex_dwen, ex_wen, ex_f_wen, flush, dmem_busy;
  logic [31:0] ex_alu_out, ex_store_data, ex_csr_rdata, ex_reg_file_wdata;
  logic [31:0] ex_fpu_out, ex_f_wdata, dmem_rdata;
  load_store_t ex_ls_type;
  logic [2:0]  ex_w_sel;
  logic [4:0]  ex_reg_rd, ex_f_reg_rd;
  logic [1:0]  ex_f_wsel;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ren, dmem_wen, mem_stall, misaligned_load, misaligned_store;
  logic [3:0]  dmem_byte_en;
  logic [31:0] mem_wb_alu_port_out, mem_wb_dload_ext, mem_wb_csr_rdata, mem_wb_reg_file_wdata;
  logic [31:0] mem_wb_fpu_out, mem_wb_f_wdata;
  logic [2:0]  mem_wb_w_sel;
  logic [1:0]  mem_wb_f_wsel;
  logic        mem_wb_wen, mem_wb_f_wen;
  logic [4:0]  mem_wb_reg_rd, mem_wb_f_reg_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  pipe5_memory_stage dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
    .ex_ls_type(ex_ls_type), .ex_w_sel(ex_w_sel), .ex_wen(ex_wen), .ex_reg_rd(ex_reg_rd),
    .ex_csr_rdata(ex_csr_rdata), .ex_reg_file_wdata(ex_reg_file_wdata),
    .ex_f_wen(ex_f_wen), .ex_f_reg_rd(ex_f_reg_rd), .ex_f_wsel(ex_f_wsel),
    .ex_fpu_out(ex_fpu_out), .ex_f_wdata(ex_f_wdata), .flush(flush),
    .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy), .dmem_addr(dmem_addr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_byte_en(dmem_byte_en),
    .dmem_wdata(dmem_wdata), .mem_stall(mem_stall), .misaligned_load(misaligned_load),
    .misaligned_store(misaligned_store), .mem_wb_alu_port_out(mem_wb_alu_port_out),
    .mem_wb_dload_ext(mem_wb_dload_ext), .mem_wb_csr_rdata(mem_wb_csr_rdata),
    .mem_wb_reg_file_wdata(mem_wb_reg_file_wdata), .mem_wb_w_sel(mem_wb_w_sel),
    .mem_wb_wen(mem_wb_wen), .mem_wb_reg_rd(mem_wb_reg_rd), .mem_wb_fpu_out(mem_wb_fpu_out),
    .mem_wb_f_wdata(mem_wb_f_wdata), .mem_wb_f_wsel(mem_wb_f_wsel),
    .mem_wb_f_wen(mem_wb_f_wen), .mem_wb_f_reg_rd(mem_wb_f_reg_rd)
  );

  typedef struct {
    logic        valid, dren, dwen, wen, f_wen;
    load_store_t ls;
    logic [31:0] addr, sd, rdata, csr, rfw, fpu, fw;
    logic [2:0]  w_sel;
    logic [4:0]  rd, f_rd;
    logic [1:0]  f_wsel;
  } txn_t;

  typedef struct {
    load_store_t ls;
    logic        dren, dwen, wen_in;
    logic [31:0] addr, sd, rdata;
    logic        e_ren, e_wen;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_ext;
    logic        e_wbwen, e_misl, e_miss;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input txn_t t, input bit fl);
    ex_valid = t.valid; ex_dren = t.dren; ex_dwen = t.dwen; ex_ls_type = t.ls;
    ex_alu_out = t.addr; ex_store_data = t.sd; ex_wen = t.wen; ex_w_sel = t.w_sel;
    ex_reg_rd = t.rd; ex_csr_rdata = t.csr; ex_reg_file_wdata = t.rfw;
    ex_f_wen = t.f_wen; ex_f_reg_rd = t.f_rd; ex_f_wsel = t.f_wsel;
    ex_fpu_out = t.fpu; ex_f_wdata = t.fw; flush = fl;
  endtask

  // Reference model: access size in bytes, derived from the load/store type.
  function automatic int size_of(input load_store_t l);
    case (l)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input load_store_t l, input logic [1:0] o, input logic [31:0] rd);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = rd >> (8 * o);
    b  = sh[7:0];
    h  = sh[15:0];
    case (l)
      LB:      begin r = b; return r; end
      LH:      begin r = h; return r; end
      LBU:     return sh & 32'hFF;
      LHU:     return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input int sz, input logic [1:0] o);
    int m;
    m = ((1 << sz) - 1) << o;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] sd);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic txn_t base_txn(input load_store_t l, input logic rd, input logic wr, input logic [31:0] a);
    txn_t t;
    t.valid = 1'b1; t.dren = rd; t.dwen = wr; t.ls = l; t.addr = a;
    t.sd = $urandom; t.rdata = $urandom; t.wen = rd; t.f_wen = 1'b0;
    t.csr = $urandom; t.rfw = $urandom; t.fpu = $urandom; t.fw = $urandom;
    t.w_sel = 3'($urandom_range(0, 7)); t.rd = 5'($urandom); t.f_rd = 5'($urandom);
    t.f_wsel = 2'($urandom);
    return t;
  endfunction

  // flush_at: -1 never, 0 in the issue cycle, k>0 from the k-th cycle on.
  task automatic run_txn(input txn_t t, input int nbusy, input int flush_at);
    int sz, ncyc;
    bit ld, st, mis, req, flushed, commit;
    sz      = size_of(t.ls);
    st      = t.dwen;
    ld      = t.dren && !t.dwen;
    mis     = (ld || st) && ((t.addr % sz) != 0);
    req     = t.valid && (ld || st) && !mis && (flush_at != 0);
    ncyc    = req ? nbusy + 1 : 1;
    flushed = (flush_at >= 0) && (flush_at < ncyc);
    commit  = t.valid && !flushed && !mis;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLK);
      drive(t, (flush_at >= 0) && (k >= flush_at));
      dmem_busy  = req ? (k < nbusy) : (nbusy > 0);
      dmem_rdata = dmem_busy ? $urandom : t.rdata;
      #2;
      chk("mem_stall", {31'd0, mem_stall}, {31'd0, req && (k < nbusy)});
      chk("dmem_ren", {31'd0, dmem_ren}, {31'd0, req && ld});
      chk("dmem_wen", {31'd0, dmem_wen}, {31'd0, req && st});
      if (req) chk("dmem_addr", dmem_addr, t.addr & 32'hFFFF_FFFC);
      if (req && st) begin
        chk("dmem_byte_en", {28'd0, dmem_byte_en}, {28'd0, model_be(sz, t.addr[1:0])});
        chk("dmem_wdata", dmem_wdata, model_wdata(sz, t.sd));
      end
      @(posedge CLK);
      #1;
      if (k < ncyc - 1) begin
        chk("stall_bubble_wen", {31'd0, mem_wb_wen}, 32'd0);
        chk("stall_bubble_f_wen", {31'd0, mem_wb_f_wen}, 32'd0);
      end
    end
    chk("wb_wen", {31'd0, mem_wb_wen}, {31'd0, t.wen && commit});
    chk("wb_f_wen", {31'd0, mem_wb_f_wen}, {31'd0, FP_EN && t.f_wen && commit});
    chk("misaligned_load", {31'd0, misaligned_load}, {31'd0, t.valid && !flushed && ld && mis});
    chk("misaligned_store", {31'd0, misaligned_store}, {31'd0, t.valid && !flushed && st && mis});
    if (commit) begin
      chk("wb_alu", mem_wb_alu_port_out, t.addr);
      chk("wb_csr", mem_wb_csr_rdata, t.csr);
      chk("wb_rfw", mem_wb_reg_file_wdata, t.rfw);
      chk("wb_w_sel", {29'd0, mem_wb_w_sel}, {29'd0, t.w_sel});
      chk("wb_reg_rd", {27'd0, mem_wb_reg_rd}, {27'd0, t.rd});
      chk("wb_fpu", mem_wb_fpu_out, t.fpu & {32{FP_EN}});
      chk("wb_f_wdata", mem_wb_f_wdata, t.fw & {32{FP_EN}});
      chk("wb_f_rd", {27'd0, mem_wb_f_reg_rd}, {27'd0, t.f_rd & {5{FP_EN}}});
      if (ld) chk("wb_dload_ext", mem_wb_dload_ext, model_load(t.ls, t.addr[1:0], t.rdata));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    txn_t t;
    int   nb, fa;

    vecs[0] = '{LB,  1'b1, 1'b0, 1'b1, 32'h1003, 32'h0, 32'h80FF_FF00, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{SB,  1'b0, 1'b1, 1'b0, 32'h3001, 32'hAB, 32'h0, 1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{LW,  1'b1, 1'b0, 1'b1, 32'h4002, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{LH,  1'b1, 1'b0, 1'b1, 32'h0002, 32'h0, 32'h8001_1234, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{LBU, 1'b1, 1'b0, 1'b1, 32'h0001, 32'h0, 32'h0000_9900, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_0099, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{SH,  1'b0, 1'b1, 1'b0, 32'h0002, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 4'b1100, 32'h5678_5678, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{SW,  1'b0, 1'b1, 1'b0, 32'h0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{SH,  1'b0, 1'b1, 1'b0, 32'h0001, 32'h5555, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{LHU, 1'b1, 1'b0, 1'b1, 32'h0003, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{LW,  1'b1, 1'b0, 1'b1, 32'h0010, 32'h0, 32'hCAFE_BABE, 1'b1, 1'b0, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b1, 1'b0, 1'b0};

    // Reset with a live load request presented: everything must stay quiet.
    nRST = 1'b0;
    t = base_txn(LW, 1'b1, 1'b0, 32'h100);
    t.f_wen = 1'b1;
    drive(t, 1'b0);
    dmem_busy = 1'b1; dmem_rdata = 32'h1234_5678;
    #12;
    chk("rst_ren", {31'd0, dmem_ren}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wb_wen", {31'd0, mem_wb_wen}, 32'd0);
    chk("rst_wb_f_wen", {31'd0, mem_wb_f_wen}, 32'd0);
    chk("rst_wb_ext", mem_wb_dload_ext, 32'd0);
    chk("rst_wb_alu", mem_wb_alu_port_out, 32'd0);
    chk("rst_misl", {31'd0, misaligned_load}, 32'd0);
    chk("rst_miss", {31'd0, misaligned_store}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      t = base_txn(vecs[i].ls, vecs[i].dren, vecs[i].dwen, vecs[i].addr);
      t.sd = vecs[i].sd; t.wen = vecs[i].wen_in;
      @(negedge CLK);
      drive(t, 1'b0);
      dmem_busy = 1'b0; dmem_rdata = vecs[i].rdata;
      #2;
      chk("vec_ren", {31'd0, dmem_ren}, {31'd0, vecs[i].e_ren});
      chk("vec_wen", {31'd0, dmem_wen}, {31'd0, vecs[i].e_wen});
      chk("vec_stall", {31'd0, mem_stall}, 32'd0);
      if (vecs[i].e_wen) begin
        chk("vec_be", {28'd0, dmem_byte_en}, {28'd0, vecs[i].e_be});
        chk("vec_wdata", dmem_wdata, vecs[i].e_wdata);
        chk("vec_addr", dmem_addr, vecs[i].addr & 32'hFFFF_FFFC);
      end
      @(posedge CLK);
      #1;
      chk("vec_wb_wen", {31'd0, mem_wb_wen}, {31'd0, vecs[i].e_wbwen});
      chk("vec_misl", {31'd0, misaligned_load}, {31'd0, vecs[i].e_misl});
      chk("vec_miss", {31'd0, misaligned_store}, {31'd0, vecs[i].e_miss});
      if (vecs[i].e_ren) chk("vec_ext", mem_wb_dload_ext, vecs[i].e_ext);
    end
    // Misaligned flag lasts exactly one cycle.
    @(negedge CLK);
    ex_valid = 1'b0;
    @(posedge CLK); #1;
    chk("misl_one_cycle", {31'd0, misaligned_load}, 32'd0);

    // LHU with three busy cycles.
    t = base_txn(LHU, 1'b1, 1'b0, 32'h2002);
    t.rdata = 32'hBEEF_1234;
    run_txn(t, 3, -1);
    chk("lhu_ext", mem_wb_dload_ext, 32'h0000_BEEF);

    // Store flushed while waiting: bus completes, result is a bubble.
    t = base_txn(SW, 1'b0, 1'b1, 32'h5000);
    t.wen = 1'b1; t.f_wen = 1'b1;
    run_txn(t, 3, 1);

    // FP load.
    t = base_txn(LW, 1'b1, 1'b0, 32'h6000);
    t.wen = 1'b0; t.f_wen = 1'b1; t.f_wsel = FWSEL_LOAD; t.rdata = 32'h3F80_0000;
    run_txn(t, 0, -1);
    chk("flw_f_wen", {31'd0, mem_wb_f_wen}, {31'd0, FP_EN});
    chk("flw_ext", mem_wb_dload_ext, 32'h3F80_0000);
    chk("flw_f_wsel", {30'd0, mem_wb_f_wsel}, {30'd0, FWSEL_LOAD & {2{FP_EN}}});

    // Reset in the middle of a wait.
    t = base_txn(LW, 1'b1, 1'b0, 32'h7000);
    @(negedge CLK);
    drive(t, 1'b0);
    dmem_busy = 1'b1;
    @(posedge CLK); #3;
    chk("wait_ren_held", {31'd0, dmem_ren}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("midrst_ren", {31'd0, dmem_ren}, 32'd0);
    chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
    chk("midrst_wb_ext", mem_wb_dload_ext, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    run_txn(t, 0, -1);

    // Randomized transactions against the model.
    for (int i = 0; i < 200; i++) begin
      int op;
      op = $urandom_range(0, 5);
      t  = base_txn(load_store_t'($urandom_range(0, 7)), 1'b0, 1'b0, $urandom);
      t.dren  = (op == 1) || (op > 1 && (t.ls inside {LB, LH, LW, LBU, LHU}));
      t.dwen  = (op == 1) || (op > 1 && !(t.ls inside {LB, LH, LW, LBU, LHU}));
      t.valid = ($urandom_range(0, 7) != 0);
      t.wen   = 1'($urandom);
      t.f_wen = 1'($urandom);
      if ($urandom_range(0, 2) == 0) t.addr[1:0] = 2'b00;
      nb = $urandom_range(0, 3);
      fa = -1;
      if ($urandom_range(0, 7) == 0) fa = 0;
      else if (nb > 0 && $urandom_range(0, 5) == 0) fa = $urandom_range(1, nb);
      run_txn(t, nb, fa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe5_memory_stage.md
Name: pipe5_memory_stage

Overview:
- Memory stage of the 5-stage pipeline; producer end of the memory/writeback interface that the writeback stage consumes.
- Takes execute-stage results and issues the data-memory load/store with a busy handshake.
- Performs load sign/zero extension and store byte-lane steering.
- Registers all writeback fields (integer and FP) into the mem/wb pipeline register; stalls upstream while memory is busy.

Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data word width (fixed 32 for RV32)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents a valid instruction
- ex_alu_out  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 (or FP rs2) store value
- ex_dren, ex_dwen  in  1 each  load / store request
- ex_ls_type  in  3  load_store_t: LB, LH, LW, LBU, LHU, SB, SH, SW
- ex_w_sel  in  3  integer writeback select: 0 load, 3 ALU, 4 CSR, other = reg_file_wdata
- ex_wen  in  1  integer register write enable
- ex_reg_rd  in  5  integer destination
- ex_csr_rdata, ex_reg_file_wdata  in  32 each  passthrough writeback sources
- ex_f_wen  in  1  FP register write enable
- ex_f_reg_rd  in  5  FP destination
- ex_f_wsel  in  2  FP writeback select: 0 FPU, 1 load, other = f_wdata
- ex_fpu_out, ex_f_wdata  in  32 each  FP passthrough sources
- flush  in  1  squash the instruction in this stage
- dmem_rdata  in  32  memory read data, valid in the cycle busy=0
- dmem_busy  in  1  memory not ready; request must be held
- dmem_addr  out  32  word-aligned address {alu_out[31:2],2'b00}
- dmem_ren, dmem_wen  out  1 each  request strobes
- dmem_byte_en  out  4  byte lanes
- dmem_wdata  out  32  lane-replicated store data
- mem_stall  out  1  hold execute and earlier stages
- misaligned_load, misaligned_store  out  1 each  exception flags (registered)
- mem_wb_* outputs  out  registered copies: alu_port_out, dload_ext, csr_rdata, reg_file_wdata, w_sel, wen, reg_rd, fpu_out, f_wdata, f_wsel, f_wen, f_reg_rd

Behaviour:
- Reset: state IDLE; every mem_wb_* output 0; misaligned flags 0; dmem strobes 0.
- FSM states: IDLE, WAIT.
- IDLE: when ex_valid & (dren|dwen) & aligned, drive the request combinationally.
  - If dmem_busy=0 in the same cycle: zero-wait completion; the mem/wb register captures on that edge.
  - Otherwise go to WAIT with mem_stall=1.
- WAIT: hold addr, strobes, byte_en and wdata constant (inputs are stable because upstream is stalled). On busy=0, capture and return to IDLE.
- mem_stall = request active & dmem_busy. It is never asserted for non-memory instructions.
- During stall the mem/wb register loads a bubble: wen=0, f_wen=0, other fields don't-care, kept at their previous values.
- Load extension, byte offset o = alu_out[1:0]:
  - LB/LBU: byte lane o, sign- or zero-extended.
  - LH/LHU: half lane alu_out[1], sign- or zero-extended.
  - LW: word.
- Store steering:
  - SB: byte_en = 1<<o, wdata = byte replicated x4.
  - SH: byte_en = 4'b0011 or 4'b1100, wdata = half replicated x2.
  - SW: byte_en = 4'b1111.
- Misalignment: LW/SW with o≠0, or LH/LHU/SH with o[0]=1.
  - No bus request is issued.
  - Matching flag is set for exactly one cycle, aligned with the mem_wb capture.
  - wen and f_wen are forced 0.
- flush in IDLE: no request is issued; bubble is captured; misaligned flags are suppressed.
- flush in WAIT: the bus transaction is completed (never aborted); the result is captured as a bubble.
- ex_valid=0: bubble is captured.
- Simultaneous dren and dwen: illegal; treated as a store.
- nRST mid-WAIT: return to IDLE immediately; strobes drop.

Optional Feature:
- Macro: RV32F_SUPPORT_EN.
- Defined: FP fields are registered as specified; ex_f_wsel=1 routes dload_ext into the FP writeback.
- Undefined: mem_wb_f_wen, mem_wb_f_reg_rd, mem_wb_f_wsel, mem_wb_fpu_out and mem_wb_f_wdata are tied 0; the FP input ports remain present but unused.

Decomposition:
- rv32i_types_pkg: load_store_t enum, word_t, and w_sel encoding constants (WSEL_LOAD=0, WSEL_ALU=3, WSEL_CSR=4).
- New package constants: FWSEL_FPU=0, FWSEL_LOAD=1.
- One sub-module, pipe5_dmem_lane_unit (combinational): load extension, store steering and misalignment detection. The stage module keeps the FSM and the pipeline register.

Test Plan:
- LB at 0x1003, busy=0, rdata=0x80FF_FF00 -> no stall; next cycle mem_wb_dload_ext=0xFFFF_FF80, wen=1.
- LHU at 0x2002, busy=1 for 3 cycles, rdata=0xBEEF_1234 -> mem_stall high 3 cycles, mem_wb wen=0 during stall; then dload_ext=0x0000_BEEF.
- SB 0xAB at 0x3001 -> byte_en=4'b0010, wdata=0xABAB_ABAB, addr=0x3000; mem_wb wen=0.
- LW at 0x4002 -> no dmem_ren; misaligned_load=1 for one cycle; mem_wb_wen=0.
- flush asserted during WAIT of SW at 0x5000 -> dmem_wen held until busy=0; captured wen=0 and f_wen=0; no exception flag.
- FLW (f_wsel=1) at 0x6000, rdata=0x3F80_0000, with RV32F_SUPPORT_EN defined -> mem_wb_f_wen=1, dload_ext=0x3F80_0000. Same stimulus without the macro -> mem_wb_f_wen=0.
